nios_vjtag_scan_master: RTL

//  Initiator end of the Nios II virtual-JTAG debug protocol. Takes one command (2-bit IR + 38-bit scan word)
//  and drives the vji_* strobe set (uir/cdr/sdr/udr/rti, tck, tdi, ir_in) the debug-module TCK/sysclk pair

---
 rtl/nios_vjtag_pkg.sv | 22 ++
 rtl/nios_vjtag_tck_gen.sv | 39 +++
 rtl/nios_vjtag_scan_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nios_vjtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG scan master.
package nios_vjtag_pkg;

  localparam int SR_W_DEF    = 38;
  localparam int IR_W_DEF    = 2;
  localparam int TCK_DIV_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI
  } vji_state_e;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/nios_vjtag_tck_gen.sv
// Bit-period phase counter: tck low for the first half-period, high for the second.
module nios_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic fall_pulse,
  output logic rise_pulse,
  output logic end_pulse,
  output logic pre_end_pulse
);

  localparam int PER = 2 * TCK_DIV;
  localparam int PW  = $clog2(PER);
  localparam logic [PW-1:0] RISE_PH = PW'(TCK_DIV);
  localparam logic [PW-1:0] LAST_PH = PW'(PER - 1);
  localparam logic [PW-1:0] PRE_PH  = PW'(PER - 2);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = '0;
    if (en && (phase_q != LAST_PH)) phase_d = phase_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= '0;
    else          phase_q <= phase_d;
  end

  assign tck           = en && (phase_q >= RISE_PH);
  assign fall_pulse    = en && (phase_q == '0);
  assign rise_pulse    = en && (phase_q == RISE_PH);
  assign end_pulse     = en && (phase_q == LAST_PH);
  assign pre_end_pulse = en && (phase_q == PRE_PH);

endmodule

// File: rtl/nios_vjtag_scan_master.sv
// Virtual-JTAG initiator: one IR + DR scan per command, returns captured tdo bits and ir_out.
//
// state | meaning
// IDLE  | ready for a command, tck parked low, rti high
// UIR   | update-IR period, ir_out sampled at the rise
// CDR   | capture-DR period
// SDR   | SR_W shift periods, tdi out / tdo in
// UDR   | update-DR period
// RTI   | run-test-idle period, response issued on the way back to IDLE
module nios_vjtag_scan_master
  import nios_vjtag_pkg::*;
#(
  parameter int SR_W    = SR_W_DEF,
  parameter int IR_W    = IR_W_DEF,
  parameter int TCK_DIV = TCK_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [SR_W-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [SR_W-1:0] rsp_data,
  output logic [IR_W-1:0] rsp_ir,
  output logic            busy,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int BW = $clog2(SR_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_W - 1);

  vji_state_e      state_q, state_d;
  logic [SR_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [IR_W-1:0] ir_in_q, ir_in_d;
  logic [SR_W-1:0] rsp_data_q, rsp_data_d;
  logic [IR_W-1:0] rsp_ir_q, rsp_ir_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            tdi_q, tdi_d;

  logic tck_en, fall_pulse, rise_pulse, end_pulse, pre_end_pulse;
  logic accept;

  assign tck_en = (state_q != ST_IDLE);
  assign accept = (state_q == ST_IDLE) && cmd_valid;

  nios_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (tck_en),
    .tck           (vji_tck),
    .fall_pulse    (fall_pulse),
    .rise_pulse    (rise_pulse),
    .end_pulse     (end_pulse),
    .pre_end_pulse (pre_end_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_q       <= '0;
      ir_in_q     <= '0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      rsp_valid_q <= 1'b0;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      ir_in_q     <= ir_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_valid_q <= rsp_valid_d;
      tdi_q       <= tdi_d;
    end
  end

  // RTI leaves one cycle early so the response lands exactly (SR_W+4) periods after accept;
  // the rti strobe stays high into IDLE, so the shortened period is invisible on the strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid)     state_d = ST_UIR;
      ST_UIR:  if (end_pulse)     state_d = ST_CDR;
      ST_CDR:  if (end_pulse)     state_d = ST_SDR;
      ST_SDR:  if (end_pulse && (bit_q == BIT_LAST)) state_d = ST_UDR;
      ST_UDR:  if (end_pulse)     state_d = ST_RTI;
      ST_RTI:  if (pre_end_pulse) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    ir_in_d     = ir_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_ir_d    = rsp_ir_q;
    rsp_valid_d = 1'b0;
    tdi_d       = tdi_q;

    if (accept) begin
      ir_in_d = cmd_ir;
      shreg_d = cmd_data;
    end
    if ((state_q == ST_UIR) && rise_pulse) rsp_ir_d = vji_ir_out;
    if (state_q == ST_SDR) begin
      if (rise_pulse) shreg_d = {vji_tdo, shreg_q[SR_W-1:1]};
      if (end_pulse)  bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
    end
    // tdi is loaded at the last cycle of a period so it is already valid on the fall cycle.
    if (end_pulse) tdi_d = (state_d == ST_SDR) ? shreg_d[0] : 1'b0;
    if ((state_q == ST_RTI) && (state_d == ST_IDLE)) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = shreg_q;
    end
  end

  always_comb begin
    vji_uir = 1'b0;
    vji_cdr = 1'b0;
    vji_sdr = 1'b0;
    vji_udr = 1'b0;
    vji_rti = 1'b0;
    case (state_q)
      ST_UIR:  vji_uir = 1'b1;
      ST_CDR:  vji_cdr = 1'b1;
      ST_SDR:  vji_sdr = 1'b1;
      ST_UDR:  vji_udr = 1'b1;
      default: vji_rti = 1'b1;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_ir_in = ir_in_q;
  assign vji_tdi   = tdi_q;

endmodule
